// File: rtl/ste_rms_bcd.sv
// Binary-to-packed-BCD converter for RMS/averager results. It uses a sequential
// double-dabble that handles one bit per clock and has a one-deep pending slot.
module ste_rms_bcd #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   din_i,
    input  logic                din_update_i,
    input  logic                clr_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                bcd_update_o,
    output logic                overflow_o,
    output logic                busy_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0]  pend_data_q, pend_data_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               upd_q, upd_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted_digits;
    logic               carry_out;
    logic               start;
    logic [DATA_W-1:0]  start_val;

    // Add-3 correction for each digit before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (digits_q[4*gi +: 4] >= 4'd5) ?
                                    (digits_q[4*gi +: 4] + 4'd3) : digits_q[4*gi +: 4];
        end
    endgenerate

    // A 1 leaving the top digit means the value does not fit in DIGITS digits.
    assign carry_out      = adj[BCD_W-1];
    assign shifted_digits = {adj[BCD_W-2:0], shreg_q[DATA_W-1]};

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        digits_d     = digits_q;
        cnt_d        = cnt_q;
        ovf_acc_d    = ovf_acc_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        bcd_d        = bcd_q;
        ovf_d        = ovf_q;
        upd_d        = 1'b0;
        start        = 1'b0;
        start_val    = din_i;

        if (clr_i) begin
            state_d      = IDLE;
            pend_valid_d = 1'b0;
            bcd_d        = '0;
            ovf_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The pending value goes first; a live strobe takes its place in the slot.
                    if (pend_valid_q) begin
                        start        = 1'b1;
                        start_val    = pend_data_q;
                        pend_valid_d = din_update_i;
                        if (din_update_i) begin
                            pend_data_d = din_i;
                        end
                    end else if (din_update_i) begin
                        start     = 1'b1;
                        start_val = din_i;
                    end
                end
                SHIFT: begin
                    digits_d  = shifted_digits;
                    shreg_d   = shreg_q << 1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    ovf_acc_d = ovf_acc_q | carry_out;
                    if (din_update_i) begin
                        pend_valid_d = 1'b1;
                        pend_data_d  = din_i;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        upd_d   = 1'b1;
                        if (ovf_acc_q | carry_out) begin
                            bcd_d = {DIGITS{4'h9}};
                            ovf_d = 1'b1;
                        end else begin
                            bcd_d = shifted_digits;
                            ovf_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start) begin
                state_d   = SHIFT;
                shreg_d   = start_val;
                digits_d  = '0;
                cnt_d     = CNT_W'(DATA_W);
                ovf_acc_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            digits_q     <= '0;
            cnt_q        <= '0;
            ovf_acc_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            upd_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            digits_q     <= digits_d;
            cnt_q        <= cnt_d;
            ovf_acc_q    <= ovf_acc_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            bcd_q        <= bcd_d;
            ovf_q        <= ovf_d;
            upd_q        <= upd_d;
        end
    end

    assign bcd_o        = bcd_q;
    assign overflow_o   = ovf_q;
    assign bcd_update_o = upd_q;
    assign busy_o       = (state_q == SHIFT);

endmodule
